// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: state encoding, queue payload and reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // PC fetched first after reset unless the instance overrides it.
  localparam logic [31:0] FETCH_RESET_PC = 32'h1eceb000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    STALL,
    DISCARD
  } fetch_state_t;

  // Instruction-queue payload; the queue stores {pc, instr} as one 64-bit word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Redirect targets may carry junk in the low bits; fetch is word-aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem read in flight and enqueues {pc, instr}.
// Latency: enqueue in the same cycle as imem_resp; 2 cycles/instr with 1-cycle memory.
// Backpressure: full_in parks the returned word in a one-entry buffer until space frees.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   imem_addr/imem_rmask      read request (rmask=4'hf for one cycle per request)
//   imem_rdata/imem_resp      read data and its one-cycle strobe
//   full_in                   instruction queue is full
//   enqueue_out/instr_out/pc_out  push into the instruction queue
//   redirect_in/redirect_pc_in    restart fetch at a new PC (highest priority)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        full_in,
  output logic        enqueue_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in
);

  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  buf_instr, buf_d;
  logic [31:0]  redirect_pc;
  logic         enq;
  fetch_pkt_t   enq_pkt;

  assign redirect_pc = align_pc(redirect_pc_in);

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    buf_d         = buf_instr;
    imem_rmask    = 4'h0;
    enq           = 1'b0;
    enq_pkt.pc    = pc;
    enq_pkt.instr = buf_instr;

    // Redirect is checked first in every state so it always wins over enqueue.
    case (state)
      FETCH: begin
        if (redirect_in) begin
          pc_d = redirect_pc;
        end else begin
          imem_rmask = 4'hf;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp) begin
          if (redirect_in) begin
            pc_d    = redirect_pc;
            state_d = FETCH;
          end else if (!full_in) begin
            enq           = 1'b1;
            enq_pkt.instr = imem_rdata;
            pc_d          = pc + 32'd4;
            state_d       = FETCH;
          end else begin
            buf_d   = imem_rdata;
            state_d = STALL;
          end
        end else if (redirect_in) begin
          // The request already issued will still answer; swallow it in DISCARD.
          pc_d    = redirect_pc;
          state_d = DISCARD;
        end
      end
      STALL: begin
        if (redirect_in) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!full_in) begin
          enq     = 1'b1;
          pc_d    = pc + 32'd4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_in) begin
          pc_d = redirect_pc;
        end
        if (imem_resp) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Nothing leaves the block while reset is held.
    if (rst) begin
      imem_rmask = 4'h0;
      enq        = 1'b0;
    end
  end

  assign imem_addr   = pc;
  assign enqueue_out = enq;
  assign instr_out   = enq_pkt.instr;
  assign pc_out      = enq_pkt.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_instr <= 32'h0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      buf_instr <= buf_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage of the out-of-order core. It owns the PC, issues one instruction-memory read at a time and pushes each returned instruction, tagged with its PC, into the instruction queue's enqueue port. It stalls on `full_out` from the queue and restarts at a new PC on a redirect from the back end, discarding any stale in-flight response.

## Interface
Parameters:
- `RESET_PC`, 32'h1eceb000, PC fetched first after reset.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  fetch address; word-aligned.
- `imem_rmask`  out  4  4'hf for exactly one cycle per request, else 4'h0.
- `imem_rdata`  in  32  instruction; valid only while `imem_resp`=1.
- `imem_resp`  in  1  one-cycle response strobe.
- `full_in`  in  1  queue `full_out`.
- `enqueue_out`  out  1  drives queue `enqueue_in`.
- `instr_out`  out  32  instruction to enqueue.
- `pc_out`  out  32  PC of `instr_out`; queue runs at DATA_WIDTH=64 with `wdata_in = {pc_out, instr_out}`.
- `redirect_in`  in  1  flush/restart request from commit.
- `redirect_pc_in`  in  32  restart target; bits [1:0] ignored and forced to 0.

## Operation
- Registers: `pc`, `buf_instr` (32), `state`.
- Exactly one outstanding memory request at a time.
- States and transitions:
  - FETCH
    - Drive `imem_addr=pc` and `imem_rmask=4'hf`, then go to WAIT.
    - If `redirect_in`: suppress the request (`rmask=0`), set `pc<=redirect_pc`, stay in FETCH.
  - WAIT
    - `imem_resp` & `redirect_in`: drop the response, `pc<=redirect_pc`, go to FETCH.
    - `imem_resp` & `!full_in`: `enqueue_out=1` with `instr_out=imem_rdata`, `pc_out=pc`; then `pc<=pc+4`, go to FETCH.
    - `imem_resp` & `full_in`: `buf_instr<=imem_rdata`, go to STALL.
    - `redirect_in` without `imem_resp`: `pc<=redirect_pc`, go to DISCARD.
  - STALL
    - `redirect_in`: drop `buf_instr`, `pc<=redirect_pc`, go to FETCH.
    - Else if `!full_in`: `enqueue_out=1` with `instr_out=buf_instr`, `pc_out=pc`; then `pc<=pc+4`, go to FETCH.
  - DISCARD (stale request in flight)
    - `imem_resp`: drop it, go to FETCH; a `redirect_in` in the same cycle also updates `pc`.
    - `redirect_in` alone: update `pc`, stay in DISCARD.
- Priority: redirect over enqueue, always. `enqueue_out` is never asserted in a redirect cycle.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hfffffffc+4 = 0).
- `enqueue_out` is never asserted while `full_in`=1. No instruction is lost or duplicated across a stall.

## Timing
- Reset: `state=FETCH`, `pc=RESET_PC`, `buf_instr=0`.
- Outputs during reset: `imem_rmask=0`, `enqueue_out=0`; `instr_out`/`pc_out`/`imem_addr` don't-care.
- First request: in the first cycle after `rst` deasserts.
- `enqueue_out`, `instr_out`, `pc_out` are combinational from `state`, `imem_resp`, `full_in`, `redirect_in`. Enqueue occurs in the same cycle as `imem_resp` when the queue is not full.
- `imem_addr`/`imem_rmask` are combinational from `state`/`pc`/`redirect_in`.
- Steady state with 1-cycle memory latency: one instruction every 2 cycles (FETCH, WAIT).
- `rst` mid-operation: abandon any in-flight request (the bench must also reset the memory model) and restart from `RESET_PC`.
- `full_in` sampled each cycle. STALL exits in the first cycle `full_in`=0, enqueuing that same cycle.

## Structure
- Shared package: `fetch_state_t` enum (FETCH, WAIT, STALL, DISCARD) and a `fetch_pkt_t` packed struct {pc, instr} for the queue payload.
- `RESET_PC` default lives in the package as a localparam, overridable per instance.
- Single module, no sub-module: one `always_ff` for registers, one `always_comb` for next-state and outputs.

## Test plan
- Reset, 1-cycle memory returning 32'h00000013 at every address: `imem_addr` sequence 1eceb000, 1eceb004, 1eceb008. `enqueue_out` pulses every 2nd cycle with `pc_out` matching each address.
- `full_in`=1 when 32'hcafebabe returns at PC 1eceb004: no enqueue and no new request while full. When `full_in` drops 3 cycles later, one enqueue of {1eceb004, cafebabe}, then fetch 1eceb008.
- `redirect_in` to 32'h1eceb100 in WAIT, with the response arriving 2 cycles later: that response is not enqueued. The next request is to 1eceb100 and the next enqueue has `pc_out`=1eceb100.
- `redirect_in` to 32'h1eceb203 in the same cycle as `imem_resp`: no enqueue. Next `imem_addr`=1eceb200.
- `redirect_in` in STALL to 32'h1eceb040: buffered instruction dropped, next enqueue `pc_out`=1eceb040.
- `rst` asserted for 2 cycles while in WAIT: `enqueue_out`=0 throughout. The first request after reset is to 1eceb000.
